uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8-bit receiver. Data width, parity mode and stop-bit count are set by parameters. Baud rate is set by a runtime NCO increment. Received words leave through a one-deep valid/ready holding register with per-word parity and framing error flags. It sits between the board RXD pin and the command/packet parser.

---
 rtl/uart_rx_param.sv | 151 +++++++++++++++
 tb/tb_uart_rx_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with NCO baud tick and one-deep valid/ready output.
// Optional UART_RX_MAJORITY_EN: 3-sample majority filter on the received bit.
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int NCO_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic [NCO_W-1:0]     baud_inc,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

  state_t state_q, state_d;
  logic [NCO_W:0] acc_q, acc_d;
  logic [1:0] sync_q, sync_d;
  logic [3:0] os_q, os_d, bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic x_q, x_d, pbad_q, pbad_d, fbad_q, fbad_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q, busy_d;
  logic tick, rb, pub, load;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] win_q, win_d;
  assign win_d = tick ? {win_q[1:0], sync_q[1]} : win_q;
  assign rb = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
`else
  logic win_q, win_d;
  assign win_d = tick ? sync_q[1] : win_q;
  assign rb = win_q;
`endif

  assign tick = acc_q[NCO_W];

  always_comb begin
    acc_d = {1'b0, acc_q[NCO_W-1:0]} + {1'b0, baud_inc};
    sync_d = {sync_q[0], rxd};
    state_d = state_q;
    os_d = os_q;
    bit_d = bit_q;
    sh_d = sh_q;
    x_d = x_q;
    pbad_d = pbad_q;
    fbad_d = fbad_q;
    pub = 1'b0;
    if (tick) begin
      os_d = os_q + 4'd1;
      case (state_q)
        IDLE: if (!rb) begin
          state_d = START;
          os_d = '0;
        end
        START: if (os_q == 4'd7) begin
          state_d = rb ? IDLE : DATA;
          os_d = '0;
          bit_d = '0;
          x_d = 1'b0;
          pbad_d = 1'b0;
          fbad_d = 1'b0;
        end
        DATA: if (os_q == 4'd15) begin
          sh_d = {rb, sh_q[DATA_BITS-1:1]};
          x_d = x_q ^ rb;
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_D) begin
            bit_d = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
        PAR: if (os_q == 4'd15) begin
          pbad_d = (PARITY == 1) ? ~(x_q ^ rb) : (x_q ^ rb);
          state_d = STOP;
        end
        STOP: if (os_q == 4'd15) begin
          fbad_d = fbad_q | ~rb;
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_S) begin
            bit_d = '0;
            pub = 1'b1;
            state_d = (fbad_q | ~rb) ? BRK : IDLE;
          end
        end
        BRK: if (rb) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    load = pub & (~valid_q | ready);
    data_d = load ? sh_q : data_q;
    perr_d = load ? pbad_q : perr_q;
    ferr_d = load ? fbad_d : ferr_q;
    valid_d = load | (valid_q & ~ready);
    ovr_d = pub & ~load;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      sync_q <= '1;
      win_q <= '1;
      os_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      x_q <= 1'b0;
      pbad_q <= 1'b0;
      fbad_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sync_q <= sync_d;
      win_q <= win_d;
      os_q <= os_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      x_q <= x_d;
      pbad_q <= pbad_d;
      fbad_q <= fbad_d;
      data_q <= data_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
      busy_q <= busy_d;
    end
  end

  assign data = data_q;
  assign valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: bench for an 8N1 receiver and a 7E2 receiver sharing clock, reset, baud and ready.
module tb_uart_rx_param;
  localparam int BC = 64;
  logic clk, rst_n, rxd0, rxd1, ready;
  logic [15:0] baud_inc;
  logic [7:0] data0;
  logic [6:0] data1;
  logic v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, b0, b1;
  logic [10:0] got0[$], got1[$], exp0[$], exp1[$];
  int checks = 0, failures = 0, ov0_cnt = 0, ov1_cnt = 0;
  bit busy_seen = 0, done = 0;

  typedef struct {
    logic [6:0] d;
    logic       pb;
    logic [1:0] st;
    logic [6:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;
  vec_t vecs[6];

  uart_rx_param dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd0), .baud_inc(baud_inc), .data(data0), .valid(v0),
    .ready(ready), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0)
  );
  uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .rxd(rxd1), .baud_inc(baud_inc), .data(data1), .valid(v1),
    .ready(ready), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (v0 && ready) got0.push_back({1'b0, data0, pe0, fe0});
    if (v1 && ready) got1.push_back({2'b00, data1, pe1, fe1});
    if (ov0) ov0_cnt++;
    if (ov1) ov1_cnt++;
    if (b0) busy_seen = 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rxd0 = v;
    else rxd1 = v;
  endtask

  task automatic send(input int sel, input logic [8:0] d, input int nd, input bit pen,
                      input logic pb, input logic [1:0] st, input int ns, input int bc);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < nd; i++) b.push_back(d[i]);
    if (pen) b.push_back(pb);
    for (int i = 0; i < ns; i++) b.push_back(st[i]);
    foreach (b[i]) begin
      drive(sel, b[i]);
      tk(bc);
    end
    drive(sel, 1'b1);
  endtask

  // Reference: even parity means data bits plus parity bit hold an even count of ones.
  function automatic logic [10:0] model(input logic [8:0] d, input bit pen, input logic pb,
                                        input logic [1:0] st, input int ns);
    logic pe = pen && ((^d) != pb);
    logic fe = (ns == 2) ? !(st[0] && st[1]) : !st[0];
    return {d, pe, fe};
  endfunction

  initial begin
    vecs[0] = '{7'h3C, 1'b1, 2'b11, 7'h3C, 1'b1, 1'b0};
    vecs[1] = '{7'h3C, 1'b0, 2'b11, 7'h3C, 1'b0, 1'b0};
    vecs[2] = '{7'h7F, 1'b1, 2'b11, 7'h7F, 1'b0, 1'b0};
    vecs[3] = '{7'h01, 1'b0, 2'b11, 7'h01, 1'b1, 1'b0};
    vecs[4] = '{7'h55, 1'b0, 2'b01, 7'h55, 1'b0, 1'b1};
    vecs[5] = '{7'h00, 1'b0, 2'b10, 7'h00, 1'b0, 1'b1};
    rst_n = 0; rxd0 = 1; rxd1 = 1; ready = 1; baud_inc = 16'd16384;
    tk(4);
    chk("rst_data", 32'(data0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_flags", {29'd0, pe0, fe0, ov0}, 0);
    chk("rst_busy", 32'(b0), 0);
    rst_n = 1;
    tk(BC);
    chk("idle_busy", 32'(b0 | b1), 0);

    // 8N1 at 115200 baud from 50 MHz
    baud_inc = 16'd2416;
    got0.delete();
    send(0, 9'hA5, 8, 0, 1'b0, 2'b11, 1, 434);
    tk(434);
    chk("a5_count", got0.size(), 1);
    if (got0.size() > 0) chk("a5_word", 32'(got0[0]), {1'b0, 8'hA5, 2'b00});
    baud_inc = 16'd16384;
    tk(BC);

    foreach (vecs[i]) begin
      got1.delete();
      send(1, {2'b00, vecs[i].d}, 7, 1, vecs[i].pb, vecs[i].st, 2, BC);
      tk(2 * BC);
      chk($sformatf("vec%0d_count", i), got1.size(), 1);
      if (got1.size() > 0)
        chk($sformatf("vec%0d_word", i), 32'(got1[0]), {2'b00, vecs[i].ed, vecs[i].epe, vecs[i].efe});
    end

    // Line held low for 20 bit times
    got0.delete();
    rxd0 = 0;
    tk(20 * BC);
    chk("brk_during", got0.size(), 1);
    rxd0 = 1;
    tk(2 * BC);
    send(0, 9'h55, 8, 0, 1'b0, 2'b11, 1, BC);
    tk(BC);
    chk("brk_count", got0.size(), 2);
    if (got0.size() == 2) begin
      chk("brk_word", 32'(got0[0]), {1'b0, 8'h00, 2'b01});
      chk("brk_next", 32'(got0[1]), {1'b0, 8'h55, 2'b00});
    end

    // Low glitches of one and five ticks
    got0.delete();
    busy_seen = 0;
    rxd0 = 0;
    tk(4);
    rxd0 = 1;
    tk(2 * BC);
`ifdef UART_RX_MAJORITY_EN
    chk("g1_busy_seen", 32'(busy_seen), 0);
`endif
    chk("g1_busy", 32'(b0), 0);
    chk("g1_words", got0.size(), 0);
    busy_seen = 0;
    rxd0 = 0;
    tk(20);
    rxd0 = 1;
    tk(2 * BC);
    chk("g5_busy_seen", 32'(busy_seen), 1);
    chk("g5_busy", 32'(b0), 0);
    chk("g5_words", got0.size(), 0);

    // Overrun with ready low
    ready = 0;
    ov0_cnt = 0;
    got0.delete();
    send(0, 9'h11, 8, 0, 1'b0, 2'b11, 1, BC);
    chk("ovr_first", 32'(ov0_cnt), 0);
    send(0, 9'h22, 8, 0, 1'b0, 2'b11, 1, BC);
    tk(BC);
    chk("ovr_data", 32'(data0), 32'h11);
    chk("ovr_valid", 32'(v0), 1);
    chk("ovr_pulse", 32'(ov0_cnt), 1);
    chk("ovr_none_taken", got0.size(), 0);
    ready = 1;
    tk(1);
    chk("ovr_drop", 32'(v0), 0);
    chk("ovr_taken", got0.size(), 1);
    if (got0.size() > 0) chk("ovr_word", 32'(got0[0]), {1'b0, 8'h11, 2'b00});

    // Reset during data bit 4 with a word held
    ready = 0;
    send(0, 9'h5A, 8, 0, 1'b0, 2'b11, 1, BC);
    tk(BC);
    chk("mr_held", 32'(v0), 1);
    rxd0 = 0; tk(BC);
    rxd0 = 1; tk(BC);
    rxd0 = 0; tk(3 * BC + BC / 2);
    chk("mr_busy", 32'(b0), 1);
    rst_n = 0;
    rxd0 = 1;
    #1;
    chk("mr_valid", 32'(v0), 0);
    chk("mr_data", 32'(data0), 0);
    chk("mr_flags", {29'd0, pe0, fe0, ov0}, 0);
    chk("mr_busy0", 32'(b0), 0);
    tk(3);
    rst_n = 1;
    ready = 1;
    got0.delete();
    tk(2 * BC);
    chk("mr_quiet", got0.size(), 0);
    send(0, 9'h81, 8, 0, 1'b0, 2'b11, 1, BC);
    tk(BC);
    chk("mr_count", got0.size(), 1);
    if (got0.size() > 0) chk("mr_word", 32'(got0[0]), {1'b0, 8'h81, 2'b00});

    // Random frames on both receivers with random ready
    got0.delete(); got1.delete(); ov0_cnt = 0; ov1_cnt = 0; done = 0;
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          logic [7:0] d0 = 8'($urandom);
          logic [6:0] d1 = 7'($urandom);
          logic s0 = ($urandom_range(0, 3) != 0);
          logic pb = 1'($urandom);
          logic [1:0] s1 = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
          exp0.push_back(model({1'b0, d0}, 0, 1'b0, {1'b1, s0}, 1));
          exp1.push_back(model({2'b00, d1}, 1, pb, s1, 2));
          fork
            send(0, {1'b0, d0}, 8, 0, 1'b0, {1'b1, s0}, 1, BC);
            send(1, {2'b00, d1}, 7, 1, pb, s1, 2, BC);
          join
          tk(3 * BC);
        end
        done = 1;
      end
      begin
        while (!done) begin
          tk(1);
          ready = 1'($urandom);
        end
      end
    join
    ready = 1;
    tk(4);
    chk("rnd0_count", got0.size(), exp0.size());
    chk("rnd1_count", got1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk($sformatf("rnd0_%0d", i), 32'(got0[i]), 32'(exp0[i]));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk($sformatf("rnd1_%0d", i), 32'(got1[i]), 32'(exp1[i]));
    chk("rnd_overrun", ov0_cnt + ov1_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
